serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//  Serial frame transmitter. Accepts a parallel word through a valid/ready handshake.
//  Shifts it out on a single line: start bit, data LSB-first, optional even parity, stop bit.
//  Drives the serial/strobe side that our sequential-circuit receivers and detectors consume.
//  Sits between a parallel producer and a one-bit serial link.
// PARAMETERS
//  DATA_W        8   data bits per frame (>=1)
//  PARITY_EN     1   1: append even-parity bit after the data; 0: no parity bit
//  CLKS_PER_BIT  4   clk cycles each serial bit is held (>=1)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  tx_valid    in   1       producer has a word on tx_data
//  tx_data     in   DATA_W  word to send; sampled only on the handshake edge
//  tx_ready    out  1       block can accept a word (IDLE only)
//  serial_out  out  1       serial line; idles high
//  frame_act   out  1       high for every cycle a frame bit is on serial_out
//  tx_done     out  1       one-cycle pulse on the last cycle of the stop bit
// BEHAVIOUR
//  Reset values:
//   - serial_out=1, frame_act=0, tx_done=0, tx_ready=0, state=IDLE.
//   - Reset takes effect immediately, including mid-frame; the partial frame is abandoned.
//   - tx_ready rises on the first posedge after reset deasserts.
//  All outputs are registered.
//  Handshake:
//   - A transfer occurs on a posedge with tx_valid=1 and tx_ready=1.
//   - On that edge, tx_data is latched into the shift register and tx_ready drops.
//   - tx_valid while tx_ready=0 is ignored; tx_data is not sampled.
//  States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//   - IDLE:   serial_out=1; on transfer -> START.
//   - START:  serial_out=0 for CLKS_PER_BIT cycles.
//   - DATA:   bit i (i=0..DATA_W-1, LSB first) held CLKS_PER_BIT cycles each.
//   - PARITY: serial_out = ^data_latched (total ones incl. parity is even), held CLKS_PER_BIT cycles.
//   - STOP:   serial_out=1 for CLKS_PER_BIT cycles.
//   - tx_done=1 during the final cycle of STOP; next edge -> IDLE with tx_ready=1.
//  Latency and frame timing:
//   - Handshake edge k: start bit is visible from cycle k+1.
//   - Frame length (1+DATA_W+PARITY_EN+1)*CLKS_PER_BIT cycles; default 44.
//   - frame_act=1 from the first start cycle through the last stop cycle inclusive.
//  Back-to-back: a word offered while the block is in IDLE is accepted on the first IDLE edge.
//   - This gives exactly one idle-high cycle between frames.
//  Counters:
//   - Bit-time counter width $clog2(CLKS_PER_BIT+1); counts 0..CLKS_PER_BIT-1, then wraps.
//   - Bit-index counter width $clog2(DATA_W+1); no other wrap-around is permitted.
//  CLKS_PER_BIT=1: each bit lasts exactly one cycle; no zero-length states.
//  Illegal/unused state encodings recover to IDLE with serial_out=1 on the next edge.
// STRUCTURE
//  Shared include (serial_frame_defs.vh):
//   - state encodings ST_IDLE/ST_START/ST_DATA/ST_PARITY/ST_STOP (3-bit);
//   - line levels LINE_IDLE=1 and START_LVL=0.
//  Sub-module bit_tick_counter:
//   - holds the CLKS_PER_BIT bit-time counter, with clear and enable;
//   - emits a one-cycle bit_end pulse.
//  FSM, shift register and output registers live in serial_frame_tx.
// TESTING
//  1. Reset asserted then released, no tx_valid:
//     -> serial_out=1, frame_act=0, tx_done=0; tx_ready=0 in reset, 1 after the first edge.
//  2. Send 0xA5 (defaults):
//     -> serial_out per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0(par),1(stop);
//     -> tx_done at cycle 44 after the handshake.
//  3. Send 0x01 with PARITY_EN=1:
//     -> parity bit 1; with PARITY_EN=0 the frame is 40 cycles and has no parity slot.
//  4. tx_valid held high with 0x3C then 0xC3:
//     -> two frames separated by exactly one idle-high cycle;
//     -> tx_data changes mid-frame do not alter bits already in flight.
//  5. Reset pulsed during DATA bit 3:
//     -> serial_out=1 and frame_act=0 asynchronously;
//     -> the next handshake starts a clean frame.
//  6. CLKS_PER_BIT=1, send 0xFF:
//     -> 11-cycle frame 0,1x8,0,1; tx_done in the 11th cycle.

Source files
------------

// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter: FSM encodings, line levels
// and the registered output bundle.
package serial_frame_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef struct packed {
    logic serial;
    logic frame_act;
    logic done;
    logic ready;
  } line_out_t;

  // Reset/recovery keeps the line high but withholds ready for one edge.
  localparam line_out_t OUT_RESET = '{serial: LINE_IDLE, frame_act: 1'b0, done: 1'b0, ready: 1'b0};
  localparam line_out_t OUT_IDLE  = '{serial: LINE_IDLE, frame_act: 1'b0, done: 1'b0, ready: 1'b1};
  localparam line_out_t OUT_START = '{serial: START_LVL, frame_act: 1'b1, done: 1'b0, ready: 1'b0};

endpackage

// File: rtl/serial_frame_tx_bit_tick.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each serial bit.
module bit_tick_counter #(
  parameter int CLKS_PER_BIT = 4,
  localparam int CW = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [CW-1:0] o_count,
  output logic          o_bit_end
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_bit_end = i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: valid/ready word in, start + LSB-first data +
// optional even parity + stop out on one line, with fully registered outputs.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 1,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              frame_act,
  output logic              tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_W + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam bit            ONE_CLK  = (CLKS_PER_BIT == 1);
  localparam logic [CW-1:0] PRE_LAST = (CLKS_PER_BIT > 1) ? CW'(CLKS_PER_BIT - 2) : '0;

  logic [2:0]        r_state,  w_state_nx;
  logic [DATA_W-1:0] r_shift,  w_shift_nx;
  logic [IW-1:0]     r_idx,    w_idx_nx;
  logic              r_parity, w_parity_nx;
  line_out_t         r_out,    w_out_nx;

  logic          w_active;
  logic          w_handshake;
  logic          w_bit_end;
  logic          w_stop_pre_last;
  logic [CW-1:0] w_count;

  assign w_active    = r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign w_handshake = tx_valid && r_out.ready && (r_state == ST_IDLE);

  bit_tick_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_tick (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (!w_active),
    .i_enable  (w_active),
    .o_count   (w_count),
    .o_bit_end (w_bit_end)
  );

  // tx_done is registered, so it is raised one edge before the final stop cycle.
  assign w_stop_pre_last = (CLKS_PER_BIT > 1) && (w_count == PRE_LAST);

  // NOTE: every always_comb output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    w_state_nx    = r_state;
    w_shift_nx    = r_shift;
    w_idx_nx      = r_idx;
    w_parity_nx   = r_parity;
    w_out_nx      = r_out;
    w_out_nx.done = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_out_nx = OUT_IDLE;
        if (w_handshake) begin
          w_state_nx  = ST_START;
          w_shift_nx  = tx_data;
          w_parity_nx = ^tx_data;
          w_idx_nx    = '0;
          w_out_nx    = OUT_START;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_state_nx      = ST_DATA;
          w_out_nx.serial = r_shift[0];
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          if (r_idx == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              w_state_nx      = ST_PARITY;
              w_out_nx.serial = r_parity;
            end else begin
              w_state_nx      = ST_STOP;
              w_out_nx.serial = LINE_IDLE;
              w_out_nx.done   = ONE_CLK;
            end
          end else begin
            w_idx_nx        = r_idx + 1'b1;
            w_shift_nx      = r_shift >> 1;
            w_out_nx.serial = w_shift_nx[0];
          end
        end
      end

      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nx      = ST_STOP;
          w_out_nx.serial = LINE_IDLE;
          w_out_nx.done   = ONE_CLK;
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          w_state_nx = ST_IDLE;
          w_out_nx   = OUT_IDLE;
        end else begin
          w_out_nx.done = w_stop_pre_last;
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
        w_out_nx   = OUT_RESET;
      end
    endcase
  end

  // NOTE: the data-path registers are reset too, so a frame abandoned by reset
  // leaves no stale word behind and simulation never sees X on them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_parity <= 1'b0;
      r_out    <= OUT_RESET;
    end else begin
      r_state  <= w_state_nx;
      r_shift  <= w_shift_nx;
      r_idx    <= w_idx_nx;
      r_parity <= w_parity_nx;
      r_out    <= w_out_nx;
    end
  end

  assign serial_out = r_out.serial;
  assign frame_act  = r_out.frame_act;
  assign tx_done    = r_out.done;
  assign tx_ready   = r_out.ready;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: three instances (defaults, no parity,
// one clock per bit); stimulus queues expected frames, monitors compare them.
module tb_serial_frame_tx;

  typedef struct {
    int          len;
    logic [63:0] lvl;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] tv;
  logic [7:0] td [3];
  logic [2:0] rdy, so, fa, dn;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int gap [3];
  int last_end [3];

  frame_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_tx u0 (
    .clk(clk), .reset(reset), .tx_valid(tv[0]), .tx_data(td[0]),
    .tx_ready(rdy[0]), .serial_out(so[0]), .frame_act(fa[0]), .tx_done(dn[0]));

  serial_frame_tx #(.PARITY_EN(0)) u1 (
    .clk(clk), .reset(reset), .tx_valid(tv[1]), .tx_data(td[1]),
    .tx_ready(rdy[1]), .serial_out(so[1]), .frame_act(fa[1]), .tx_done(dn[1]));

  serial_frame_tx #(.CLKS_PER_BIT(1)) u2 (
    .clk(clk), .reset(reset), .tx_valid(tv[2]), .tx_data(td[2]),
    .tx_ready(rdy[2]), .serial_out(so[2]), .frame_act(fa[2]), .tx_done(dn[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // seq[b] is the line level of serial bit b (bit 0 = start bit).
  function automatic frame_t mk(input logic [15:0] seq, input int nbits, input int cpb);
    frame_t f;
    f.len = nbits * cpb;
    f.lvl = '0;
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < cpb; c++)
        f.lvl[b*cpb + c] = seq[b];
    return f;
  endfunction

  function automatic void push(input int id, input frame_t f);
    case (id)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic frame_t qpop(input int id);
    case (id)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic monitor(input int id);
    int          cnt = 0;
    int          done_pos = -1;
    int          done_cnt = 0;
    logic [63:0] got = '0;
    frame_t      e;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0; got = '0; done_pos = -1; done_cnt = 0;
      end else if (fa[id]) begin
        if (cnt == 0) gap[id] = cyc - last_end[id];
        if (cnt < 64) got[cnt] = so[id];
        if (dn[id]) begin
          done_pos = cnt;
          done_cnt++;
        end
        cnt++;
      end else if (cnt > 0) begin
        last_end[id] = cyc;
        if (qsize(id) == 0) begin
          check($sformatf("u%0d unexpected frame length", id), cnt, 0);
        end else begin
          e = qpop(id);
          check($sformatf("u%0d frame levels", id), got, e.lvl);
          check($sformatf("u%0d frame length", id), cnt, e.len);
          check($sformatf("u%0d tx_done position", id), done_pos, e.len - 1);
          check($sformatf("u%0d tx_done pulses", id), done_cnt, 1);
        end
        cnt = 0; got = '0; done_pos = -1; done_cnt = 0;
      end
    end
  endtask

  // Called at a negedge; returns at a negedge with tx_ready high or after the budget.
  task automatic wait_ready(input int id);
    int t = 0;
    while (!rdy[id] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[id]) check($sformatf("u%0d tx_ready timeout", id), rdy[id], 1'b1);
  endtask

  task automatic send(input int id, input logic [7:0] d, input frame_t e);
    wait_ready(id);
    push(id, e);
    td[id] = d;
    tv[id] = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("u%0d start bit one cycle after handshake {act,ser,rdy}", id),
          {fa[id], so[id], rdy[id]}, 3'b100);
    tv[id] = 1'b0;
    td[id] = 8'h00;
  endtask

  task automatic wait_idle(input int id);
    @(negedge clk);
    wait_ready(id);
    @(negedge clk);
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      td[i] = 8'h00;
      gap[i] = 0;
      last_end[i] = 0;
    end
    tv    = 3'b000;
    reset = 1'b1;

    // Reset values, then tx_ready on the first edge after release.
    repeat (3) @(negedge clk);
    check("u0 in reset {rdy,ser,act,done}", {rdy[0], so[0], fa[0], dn[0]}, 4'b0100);
    check("u2 in reset {rdy,ser,act,done}", {rdy[2], so[2], fa[2], dn[2]}, 4'b0100);
    reset = 1'b0;
    #1;
    check("u0 tx_ready before first edge", rdy[0], 1'b0);
    @(posedge clk);
    #1;
    check("u0 tx_ready after first edge", rdy[0], 1'b1);
    check("u0 idle line after reset {ser,act}", {so[0], fa[0]}, 2'b10);
    @(negedge clk);

    // 0xA5: 0 | 1,0,1,0,0,1,0,1 | par 0 | stop 1
    send(0, 8'hA5, mk(16'b1_0_10100101_0, 11, 4));
    wait_idle(0);

    // 0x01 with parity (par 1) and without parity (40-cycle frame)
    send(0, 8'h01, mk(16'b1_1_00000001_0, 11, 4));
    wait_idle(0);
    send(1, 8'h01, mk(16'b1_00000001_0, 10, 4));
    wait_idle(1);

    // Back-to-back with tx_valid held: 0x3C then 0xC3, data changed mid-frame.
    wait_ready(0);
    push(0, mk(16'b1_0_00111100_0, 11, 4));
    push(0, mk(16'b1_0_11000011_0, 11, 4));
    td[0] = 8'h3C;
    tv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    td[0] = 8'hC3;
    wait_ready(0);
    @(posedge clk);
    #1;
    check("u0 second frame starts {act,ser}", {fa[0], so[0]}, 2'b10);
    tv[0] = 1'b0;
    td[0] = 8'h00;
    wait_idle(0);
    check("u0 idle cycles between back-to-back frames", gap[0], 1);

    // Reset during data bit 3 of 0x5A, then a clean 0x80 frame.
    send(0, 8'h5A, mk(16'b1_0_01011010_0, 11, 4));
    repeat (17) @(posedge clk);
    #2;
    check("u0 frame active before mid-frame reset", fa[0], 1'b1);
    reset = 1'b1;
    void'(q0.pop_back());
    #1;
    check("u0 async reset mid-frame {ser,act,done,rdy}", {so[0], fa[0], dn[0], rdy[0]}, 4'b1000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(0, 8'h80, mk(16'b1_1_10000000_0, 11, 4));
    wait_idle(0);

    // CLKS_PER_BIT=1, 0xFF: 0, 1x8, par 0, stop 1
    send(2, 8'hFF, mk(16'b1_0_11111111_0, 11, 1));
    wait_idle(2);

    repeat (4) @(negedge clk);
    check("u0 scoreboard drained", q0.size(), 0);
    check("u1 scoreboard drained", q1.size(), 0);
    check("u2 scoreboard drained", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
